// File: rtl/sprite_pkg.sv
// Shared types and 720p timing defaults for the sprite BRAM blocks.
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, WRITING, DONE} load_state_t;

  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_TOTAL_720P  = 750;
  localparam int unsigned H_TOTAL_720P  = 1650;
endpackage

// File: rtl/blank_window_detect.sv
// Vertical-blanking write window: open from the first blank line until GUARD
// cycles before the frame wraps. Purely combinational.
module blank_window_detect
  import sprite_pkg::*;
#(
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_TOTAL  = V_TOTAL_720P,
  parameter int unsigned H_TOTAL  = H_TOTAL_720P,
  parameter int unsigned GUARD    = 4
) (
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        win_out
);
  localparam logic [9:0]  V_ACT_L   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST_L  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_GUARD_L = 11'(H_TOTAL - GUARD);

  always_comb begin
    win_out = (vcount_in >= V_ACT_L) &&
              !((vcount_in == V_LAST_L) && (hcount_in >= H_GUARD_L));
  end
endmodule

// File: rtl/sprite_bram_loader_arbiter.sv
// Shares the sprite BRAM port between the display read path and a streaming
// loader that may only write inside the vertical-blanking window.
module sprite_bram_loader_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH    = 256,
  parameter int unsigned HEIGHT   = 256,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_TOTAL  = V_TOTAL_720P,
  parameter int unsigned H_TOTAL  = H_TOTAL_720P,
  parameter int unsigned GUARD    = 4,
  localparam int unsigned DEPTH   = WIDTH * HEIGHT,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic [AW-1:0] disp_addr_in,
  input  logic          load_start_in,
  input  logic          load_abort_in,
  input  logic [7:0]    wr_data_in,
  input  logic          wr_valid_in,
  output logic          wr_ready_out,
  output logic [AW-1:0] bram_addr_out,
  output logic [7:0]    bram_din_out,
  output logic          bram_we_out,
  output logic          load_busy_out,
  output logic          load_done_out,
  output logic [AW-1:0] wr_addr_out
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  load_state_t   state_q, state_d;
  logic [AW-1:0] wa_q, wa_d;
  logic          win;
  logic          beat;

  blank_window_detect #(
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .H_TOTAL  (H_TOTAL),
    .GUARD    (GUARD)
  ) u_win (
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .win_out   (win)
  );

  always_comb begin
    wr_ready_out  = (state_q == WRITING) && win && !load_abort_in;
    beat          = wr_valid_in && wr_ready_out;
    load_busy_out = (state_q == ARMED) || (state_q == WRITING);
    load_done_out = (state_q == DONE);
    wr_addr_out   = wa_q;
    if (beat) begin
      bram_addr_out = wa_q;
      bram_din_out  = wr_data_in;
      bram_we_out   = 1'b1;
    end else begin
      bram_addr_out = disp_addr_in;
      bram_din_out  = '0;
      bram_we_out   = 1'b0;
    end
  end

  // Abort is checked first in every state so it beats start, a beat and DONE.
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    unique case (state_q)
      IDLE: begin
        if (load_start_in && !load_abort_in) begin
          state_d = ARMED;
          wa_d    = '0;
        end
      end
      ARMED: begin
        if (load_abort_in) begin
          state_d = IDLE;
          wa_d    = '0;
        end else if (win) begin
          state_d = WRITING;
        end
      end
      WRITING: begin
        if (load_abort_in) begin
          state_d = IDLE;
          wa_d    = '0;
        end else if (!win) begin
          state_d = ARMED;
        end else if (beat) begin
          if (wa_q == LAST_ADDR) begin
            state_d = DONE;
            wa_d    = '0;
          end else begin
            wa_d = wa_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wa_d    = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
    end
  end
endmodule

// File: tb/tb_sprite_bram_loader_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for window
// pause/resume, abort and reset, then random stimulus against a load model.
module tb_sprite_bram_loader_arbiter;
  localparam int WIDTH = 4, HEIGHT = 4, VA = 4, VT = 6, HT = 12, G = 2;
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, valid;
  logic [7:0]    data;
  logic [AW-1:0] disp;
  int            v_cur, h_cur;
  logic [10:0]   hc;
  logic [9:0]    vc;
  logic          ready_o, we_o, busy_o, done_o;
  logic [AW-1:0] addr_o, wa_o;
  logic [7:0]    din_o;

  assign hc = 11'(h_cur);
  assign vc = 10'(v_cur);

  sprite_bram_loader_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_TOTAL(HT), .GUARD(G)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .disp_addr_in(disp), .load_start_in(start), .load_abort_in(abort),
    .wr_data_in(data), .wr_valid_in(valid), .wr_ready_out(ready_o),
    .bram_addr_out(addr_o), .bram_din_out(din_o), .bram_we_out(we_o),
    .load_busy_out(busy_o), .load_done_out(done_o), .wr_addr_out(wa_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (v=%0d h=%0d t=%0t)", name, act, exp, v_cur, h_cur, $time);
    end
  endtask

  function automatic bit win_f(int v, int h);
    return (v >= VA) && !(v == VT - 1 && h >= HT - G);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst; int v; int h; int disp; logic start, abort, valid;
    logic e_ready, e_we; int e_addr; logic e_busy, e_done; int e_wa;
  } vec_t;

  function automatic vec_t mk(logic r, int v, int h, int d, logic s, logic a, logic vl,
                              logic er, logic ew, int ea, logic eb, logic ed, int ewa);
    vec_t t;
    t.rst = r; t.v = v; t.h = h; t.disp = d; t.start = s; t.abort = a; t.valid = vl;
    t.e_ready = er; t.e_we = ew; t.e_addr = ea; t.e_busy = eb; t.e_done = ed; t.e_wa = ewa;
    return t;
  endfunction

  vec_t tv[18];

  // ---------------- behavioural load model ----------------
  bit m_busy, m_granted, m_done;
  int m_prog;
  bit obs_ready, obs_we, obs_busy, obs_done;
  int obs_addr, obs_wa, obs_v, obs_h;

  task automatic step();
    bit w, e_ready, e_we;
    int e_addr, e_din;
    @(negedge clk);
    w       = win_f(v_cur, h_cur);
    e_ready = m_busy && m_granted && w && !abort;
    e_we    = valid && e_ready;
    e_addr  = e_we ? m_prog : int'(disp);
    e_din   = e_we ? int'(data) : 0;
    chk("wr_ready", ready_o, e_ready);
    chk("bram_we", we_o, e_we);
    chk("bram_addr", addr_o, e_addr);
    chk("bram_din", din_o, e_din);
    chk("load_busy", busy_o, m_busy);
    chk("load_done", done_o, m_done);
    chk("wr_addr", wa_o, m_prog);
    obs_ready = ready_o; obs_we = we_o; obs_busy = busy_o; obs_done = done_o;
    obs_addr = int'(addr_o); obs_wa = int'(wa_o); obs_v = v_cur; obs_h = h_cur;
    if (rst) begin
      m_busy = 0; m_granted = 0; m_done = 0; m_prog = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin m_busy = 1; m_granted = 0; m_prog = 0; end
    end else if (abort) begin
      m_busy = 0; m_granted = 0; m_prog = 0;
    end else if (!m_granted) begin
      if (w) m_granted = 1;
    end else if (!w) begin
      m_granted = 0;
    end else if (e_we) begin
      if (m_prog == DEPTH - 1) begin
        m_busy = 0; m_granted = 0; m_done = 1; m_prog = 0;
      end else m_prog++;
    end
    @(posedge clk); #1;
    h_cur++;
    if (h_cur == HT) begin h_cur = 0; v_cur++; if (v_cur == VT) v_cur = 0; end
  endtask

  task automatic do_reset();
    start = 0; abort = 0; valid = 0; rst = 1;
    step(); step();
    rst = 0;
  endtask

  initial begin
    int nxt, cyc, last_we, beats;
    bit seen, hit;
    rst = 1; start = 0; abort = 0; valid = 0; data = 8'hA5; disp = 4'd5;
    v_cur = 0; h_cur = 0;

    tv[0]  = mk(1,0,0,5,0,0,0, 0,0,5,0,0,0);
    tv[1]  = mk(1,0,0,5,0,0,0, 0,0,5,0,0,0);
    tv[2]  = mk(0,1,0,5,1,0,1, 0,0,5,0,0,0);
    tv[3]  = mk(0,1,1,5,0,0,1, 0,0,5,1,0,0);
    tv[4]  = mk(0,3,11,5,0,0,1, 0,0,5,1,0,0);
    tv[5]  = mk(0,4,0,5,0,0,1, 0,0,5,1,0,0);
    tv[6]  = mk(0,4,1,5,0,0,1, 1,1,0,1,0,0);
    tv[7]  = mk(0,4,2,9,0,0,0, 1,0,9,1,0,1);
    tv[8]  = mk(0,4,3,9,0,0,1, 1,1,1,1,0,1);
    tv[9]  = mk(0,0,0,9,0,0,1, 0,0,9,1,0,2);
    tv[10] = mk(0,4,0,9,0,0,1, 0,0,9,1,0,2);
    tv[11] = mk(0,4,1,9,0,0,1, 1,1,2,1,0,2);
    tv[12] = mk(0,5,10,9,0,0,1, 0,0,9,1,0,3);
    tv[13] = mk(0,5,9,9,1,0,1, 0,0,9,1,0,3);
    tv[14] = mk(0,5,9,9,0,1,1, 0,0,9,1,0,3);
    tv[15] = mk(0,5,9,9,0,0,1, 0,0,9,0,0,0);
    tv[16] = mk(0,5,9,9,1,1,1, 0,0,9,0,0,0);
    tv[17] = mk(0,5,9,9,0,0,1, 0,0,9,0,0,0);

    for (int i = 0; i < 18; i++) begin
      rst = tv[i].rst; v_cur = tv[i].v; h_cur = tv[i].h; disp = AW'(tv[i].disp);
      start = tv[i].start; abort = tv[i].abort; valid = tv[i].valid;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), ready_o, tv[i].e_ready);
      chk($sformatf("vec%0d_we", i), we_o, tv[i].e_we);
      chk($sformatf("vec%0d_addr", i), addr_o, tv[i].e_addr);
      chk($sformatf("vec%0d_din", i), din_o, tv[i].e_we ? 32'hA5 : 32'h0);
      chk($sformatf("vec%0d_busy", i), busy_o, tv[i].e_busy);
      chk($sformatf("vec%0d_done", i), done_o, tv[i].e_done);
      chk($sformatf("vec%0d_wa", i), wa_o, tv[i].e_wa);
      @(posedge clk); #1;
    end

    // Full load started in active video: writes only in blanking, 0..15 in order.
    v_cur = 0; h_cur = 0; disp = 4'd5;
    do_reset();
    v_cur = 1; h_cur = 0; start = 1; valid = 1; step(); start = 0;
    nxt = 0; seen = 0; last_we = -10;
    for (cyc = 0; cyc < 300; cyc++) begin
      data = 8'($urandom); step();
      if (obs_we) begin
        chk("full_seq_addr", obs_addr, nxt);
        chk("full_we_in_blank", obs_v >= VA, 1);
        nxt++; last_we = cyc;
      end
      if (obs_done) begin
        seen = 1;
        chk("full_beats", nxt, DEPTH);
        chk("full_busy_with_done", obs_busy, 0);
        chk("full_done_latency", cyc - last_we, 1);
        break;
      end
    end
    chk("full_done_seen", seen, 1);

    // Pause at the guard, resume next frame at the held address.
    do_reset();
    v_cur = 4; h_cur = 10; start = 1; valid = 1; step(); start = 0;
    beats = 0; hit = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (obs_v == 5 && obs_h == 10) begin hit = 1; break; end
      if (obs_we) beats++;
    end
    chk("pause_reached", hit, 1);
    chk("pause_beats", beats, 10);
    chk("pause_ready", obs_ready, 0);
    chk("pause_wa", obs_wa, 10);
    step();
    chk("pause_busy", obs_busy, 1);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (obs_we) begin hit = 1; break; end
    end
    chk("resume_seen", hit, 1);
    chk("resume_addr", obs_addr, 10);
    chk("resume_vcount", obs_v, VA);

    // Abort on the final beat, with a start pulsed while busy.
    do_reset();
    v_cur = 4; h_cur = 0; start = 1; valid = 1; step(); start = 0;
    hit = 0;
    for (int k = 0; k < 300; k++) begin
      abort = (m_busy && m_granted && win_f(v_cur, h_cur) && m_prog == DEPTH - 1);
      start = (m_prog == 5);
      step();
      if (abort) begin hit = 1; chk("abort_no_we", obs_we, 0); break; end
    end
    abort = 0; start = 0;
    chk("abort_reached", hit, 1);
    step();
    chk("abort_idle", obs_busy, 0);
    chk("abort_wa", obs_wa, 0);
    for (int k = 0; k < 3; k++) begin step(); chk("abort_no_done", obs_done, 0); end

    // Reset mid-load discards progress; a new load restarts at 0.
    do_reset();
    v_cur = 4; h_cur = 0; start = 1; valid = 1; step(); start = 0;
    hit = 0;
    for (int k = 0; k < 300; k++) begin
      if (m_busy && m_prog == 7) begin rst = 1; step(); rst = 0; hit = 1; break; end
      step();
    end
    chk("rst_reached", hit, 1);
    step();
    chk("rst_busy", obs_busy, 0);
    chk("rst_wa", obs_wa, 0);
    start = 1; step(); start = 0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (obs_we) begin hit = 1; break; end
    end
    chk("restart_seen", hit, 1);
    chk("restart_addr", obs_addr, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 149) == 0);
      valid = ($urandom_range(0, 9) < 7);
      data  = 8'($urandom);
      disp  = AW'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
